flash_boot_loader: RTL and testbench



---
 rtl/boot_pkg.sv | 24 ++
 rtl/word_packer.sv | 39 +++
 rtl/flash_boot_loader.sv | 164 ++++++++++++++++
 tb/tb_flash_boot_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and constants for the flash boot loader
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAGIC,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_MAGIC = 2'd1,
        ERR_LEN   = 2'd2,
        ERR_CSUM  = 2'd3
    } err_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

endpackage

// File: rtl/word_packer.sv
// rtl/word_packer.sv - assembles bytes into big-endian words, flags the last byte of each word
module word_packer #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic [7:0]              byte_i,
    output logic [8*WORD_BYTES-1:0] word_o,
    output logic                    word_done_o
);

    localparam int W     = 8 * WORD_BYTES;
    localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [W-1:0]     shreg_q;
    logic [CNT_W-1:0] cnt_q;

    // word_o already includes the byte on byte_i, so the owner can capture a
    // complete word on the same edge that consumes its final byte
    assign word_o      = W'({shreg_q, byte_i});
    assign word_done_o = en_i && (cnt_q == CNT_W'(WORD_BYTES - 1));

    // shift accepted bytes in from the LSB end and count position within the word
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (clear_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (en_i) begin
            shreg_q <= word_o;
            cnt_q   <= word_done_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/flash_boot_loader.sv
// rtl/flash_boot_loader.sv - parses a boot image byte stream and writes its payload to memory
module flash_boot_loader
    import boot_pkg::*;
#(
    parameter int         WORD_BYTES = 4,
    parameter int         ADDR_W     = 10,
    parameter logic [7:0] MAGIC      = MAGIC_DEFAULT,
    parameter int         BASE_ADDR  = 0
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              err
);

    localparam int          W         = 8 * WORD_BYTES;
    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

    state_t              state_q;
    err_t                err_q;
    logic                busy_q;
    logic                done_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [W-1:0]        mem_wdata_q;
    logic [15:0]         len_q;
    logic [15:0]         words_q;
    logic [7:0]          csum_q;

    logic                idle_like;
    logic                packer_en;
    logic                packer_clear;
    logic [W-1:0]        packer_word;
    logic                packer_word_done;
    logic [15:0]         len_n;

    assign idle_like    = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
    assign packer_clear = idle_like && start;
    assign packer_en    = (state_q == ST_PAYLOAD) && byte_valid;
    assign len_n        = {len_q[15:8], byte_data};

    word_packer #(
        .WORD_BYTES (WORD_BYTES)
    ) u_packer (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear_i     (packer_clear),
        .en_i        (packer_en),
        .byte_i      (byte_data),
        .word_o      (packer_word),
        .word_done_o (packer_word_done)
    );

    // header/payload/checksum parser with all outputs registered
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            err_q       <= ERR_NONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ADDR_W'(BASE_ADDR);
            mem_wdata_q <= '0;
            len_q       <= '0;
            words_q     <= '0;
            csum_q      <= '0;
        end else begin
            mem_we_q <= 1'b0;
            // address advances the cycle after each write pulse
            if (mem_we_q) begin
                mem_addr_q <= mem_addr_q + ADDR_W'(1);
            end
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_q    <= ST_MAGIC;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= ERR_NONE;
                        len_q      <= '0;
                        words_q    <= '0;
                        csum_q     <= '0;
                        mem_addr_q <= ADDR_W'(BASE_ADDR);
                    end
                end
                ST_MAGIC: begin
                    if (byte_valid) begin
                        if (byte_data == MAGIC) begin
                            state_q <= ST_LEN_HI;
                        end else begin
                            state_q <= ST_ERROR;
                            err_q   <= ERR_MAGIC;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_LEN_HI: begin
                    if (byte_valid) begin
                        len_q[15:8] <= byte_data;
                        state_q     <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (byte_valid) begin
                        len_q[7:0] <= byte_data;
                        if (32'(len_n) > MAX_WORDS) begin
                            state_q <= ST_ERROR;
                            err_q   <= ERR_LEN;
                            busy_q  <= 1'b0;
                        end else if (len_n == 16'd0) begin
                            state_q <= ST_CHECK;
                        end else begin
                            state_q <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (byte_valid) begin
                        csum_q <= csum_q + byte_data;
                        if (packer_word_done) begin
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= packer_word;
                            words_q     <= words_q + 16'd1;
                            if ((17'(words_q) + 17'd1) == 17'(len_q)) begin
                                state_q <= ST_CHECK;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    if (byte_valid) begin
                        busy_q <= 1'b0;
                        if (byte_data == csum_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ERROR;
                            err_q   <= ERR_CSUM;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_flash_boot_loader.sv
// tb/tb_flash_boot_loader.sv - scoreboard bench for flash_boot_loader
module tb_flash_boot_loader;

    localparam int         WB      = 4;
    localparam int         AW      = 2;
    localparam int         BASE    = 2;
    localparam logic [7:0] MAGIC_B = 8'hA5;
    localparam int         DEPTH   = 1 << AW;

    logic            clk;
    logic            n_rst;
    logic            start;
    logic            byte_valid;
    logic [7:0]      byte_data;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [8*WB-1:0] mem_wdata;
    logic            busy;
    logic            done;
    logic [1:0]      err;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [8*WB-1:0] data;
    } wr_t;

    typedef struct {
        logic       done;
        logic [1:0] err;
    } res_t;

    wr_t        wr_q[$];
    res_t       res_q[$];
    logic [7:0] pl_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    logic prev_busy = 1'b0;
    logic prev_bv   = 1'b0;

    flash_boot_loader #(
        .WORD_BYTES (WB),
        .ADDR_W     (AW),
        .MAGIC      (MAGIC_B),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // monitor: pops expected writes on mem_we and expected outcomes when busy falls
    always @(negedge clk) begin
        if (!n_rst) begin
            prev_busy = 1'b0;
            prev_bv   = 1'b0;
        end else begin
            if (mem_we) begin
                check("write_latency", 64'(prev_bv), 64'd1);
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 64'(mem_addr), 64'hFFFF);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("write_addr", 64'(mem_addr), 64'(w.addr));
                    check("write_data", 64'(mem_wdata), 64'(w.data));
                end
            end
            if (prev_busy && !busy) begin
                if (res_q.size() == 0) begin
                    check("unexpected_finish", 64'(err), 64'hFF);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("done", 64'(done), 64'(r.done));
                    check("err", 64'(err), 64'(r.err));
                    check("writes_outstanding", 64'(wr_q.size()), 64'd0);
                end
            end
            prev_busy = busy;
            prev_bv   = byte_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        byte_valid = 1'b1;
        byte_data  = b;
        start      = with_start;
        tick();
        byte_valid = 1'b0;
        start      = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_start(input bit with_byte);
        start      = 1'b1;
        byte_valid = with_byte;
        byte_data  = MAGIC_B;
        tick();
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 400) begin
            tick();
            k++;
        end
        if (k >= 400) check("busy_timeout", 64'(busy), 64'd0);
        repeat (2) tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'(BASE));
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    // reference: image = magic, 16-bit word count, payload words, payload byte sum mod 256
    task automatic run_image(input logic [7:0] magic, input int n, input int csum_delta,
                             input int max_gap, input bit start_byte, input bit start_mid);
        logic [7:0]      bytes[$];
        logic [7:0]      sum;
        logic [8*WB-1:0] d;
        res_t            r;
        wr_t             w;
        sum = 8'd0;
        bytes.push_back(magic);
        if (magic != MAGIC_B) begin
            r = '{1'b0, 2'd1};
        end else begin
            bytes.push_back(8'(n >> 8));
            bytes.push_back(8'(n));
            if (n > DEPTH) begin
                r = '{1'b0, 2'd2};
            end else begin
                for (int i = 0; i < n; i++) begin
                    d = '0;
                    for (int b = 0; b < WB; b++) begin
                        d = (d << 8) | (8*WB)'(pl_q[i*WB + b]);
                        sum = sum + pl_q[i*WB + b];
                        bytes.push_back(pl_q[i*WB + b]);
                    end
                    w.addr = AW'((BASE + i) % DEPTH);
                    w.data = d;
                    wr_q.push_back(w);
                end
                bytes.push_back(sum + 8'(csum_delta));
                if (csum_delta == 0) r = '{1'b1, 2'd0};
                else                 r = '{1'b0, 2'd3};
            end
        end
        res_q.push_back(r);
        do_start(start_byte);
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0,
                      start_mid && (i == bytes.size() / 2));
        end
        send_byte(8'($urandom), 0, 1'b0);
        wait_idle();
    endtask

    task automatic load_nominal();
        logic [7:0] nom [8];
        nom = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        pl_q.delete();
        foreach (nom[i]) pl_q.push_back(nom[i]);
    endtask

    task automatic load_random(input int n);
        pl_q.delete();
        for (int i = 0; i < n * WB; i++) pl_q.push_back(8'($urandom));
    endtask

    initial begin
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        n_rst      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        tick();

        // nominal image, bytes back to back
        load_nominal();
        run_image(MAGIC_B, 2, 0, 0, 1'b0, 1'b0);
        check("done_held", 64'(done), 64'd1);

        // bad magic, then a good image restarting at the base address
        run_image(8'h5A, 0, 0, 0, 1'b0, 1'b0);
        check("err_held", 64'(err), 64'd1);
        load_nominal();
        run_image(MAGIC_B, 2, 0, 1, 1'b0, 1'b0);

        // zero length: good and bad checksum
        run_image(MAGIC_B, 0, 0, 0, 1'b0, 1'b0);
        run_image(MAGIC_B, 0, 1, 0, 1'b0, 1'b0);

        // bad checksum after both words written
        load_nominal();
        run_image(MAGIC_B, 2, 1, 0, 1'b0, 1'b0);

        // length boundary: one over is rejected, exactly full memory wraps the address
        run_image(MAGIC_B, DEPTH + 1, 0, 0, 1'b0, 1'b0);
        load_random(DEPTH);
        run_image(MAGIC_B, DEPTH, 0, 0, 1'b0, 1'b0);

        // start with a byte in the same cycle drops the byte; start mid-image is ignored
        load_nominal();
        run_image(MAGIC_B, 2, 0, 0, 1'b1, 1'b1);

        // reset mid-payload, after one word and part of the next
        do_start(1'b0);
        send_byte(MAGIC_B, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        begin
            wr_t w;
            w.addr = AW'(BASE);
            w.data = 32'hCAFEF00D;
            wr_q.push_back(w);
        end
        send_byte(8'hCA, 0, 1'b0);
        send_byte(8'hFE, 0, 1'b0);
        send_byte(8'hF0, 0, 1'b0);
        send_byte(8'h0D, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'h22;
        n_rst      = 1'b0;
        #1;
        check_reset_values("async_reset");
        byte_valid = 1'b0;
        @(posedge clk);
        #1;
        check("reset_write_flushed", 64'(wr_q.size()), 64'd0);
        n_rst = 1'b1;
        tick();
        load_nominal();
        run_image(MAGIC_B, 2, 0, 0, 1'b0, 1'b0);

        // randomized images
        for (int t = 0; t < 40; t++) begin
            int         kind;
            int         n;
            int         delta;
            logic [7:0] magic;
            kind  = $urandom_range(0, 9);
            n     = $urandom_range(0, DEPTH);
            delta = 0;
            magic = MAGIC_B;
            load_random(n);
            if (kind == 0) begin
                magic = 8'($urandom_range(0, 255));
                if (magic == MAGIC_B) magic = 8'h5A;
            end
            if (kind == 1) n = $urandom_range(DEPTH + 1, 65535);
            if (kind == 2) delta = $urandom_range(1, 255);
            run_image(magic, n, delta, $urandom_range(0, 1) * 2,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        check("final_writes_pending", 64'(wr_q.size()), 64'd0);
        check("final_results_pending", 64'(res_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
